// File: rtl/arcade_cfg_pkg.sv
// Shared types and default ioctl index assignments for the arcade configuration loader.
package arcade_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } dl_state_t;

  localparam int ROM_IDX = 0;
  localparam int MOD_IDX = 1;
  localparam int DIP_IDX = 254;

endpackage

// File: rtl/arcade_cfg_loader_if.sv
// hps_io ioctl download bus as seen by the arcade configuration loader.
interface arcade_cfg_loader_if #(
  parameter int ADDR_W = 25
);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [7:0]        ioctl_index;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );

  modport slave (
    input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index
  );
endinterface

// File: rtl/arcade_cfg_loader_dl_reset_seq.sv
// ROM download tracker: holds the game core in reset while a ROM is loading
// and for HOLD_CYCLES afterwards, and until the first ROM load has completed.
module dl_reset_seq
  import arcade_cfg_pkg::*;
#(
  parameter int HOLD_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic download,
  input  logic rom_sel,
  input  logic reset_req,
  output logic rom_loaded,
  output logic rom_valid,
  output logic core_reset
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_LOAD = LOAD;
  localparam logic [1:0] ST_HOLD = HOLD;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          loaded_next;
  logic          rom_start;

  assign rom_start = download & rom_sel;

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    loaded_next = 1'b0;
    case (state_reg)
      ST_IDLE: if (rom_start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (!download) begin
          state_next = ST_HOLD;
          count_next = HOLD_INIT;
        end
      end
      ST_HOLD: begin
        // A new ROM download restarts the load; the pending hold is abandoned.
        if (rom_start) begin
          state_next = ST_LOAD;
        end else if (count_reg == '0) begin
          state_next  = ST_IDLE;
          loaded_next = 1'b1;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      rom_loaded <= 1'b0;
      rom_valid  <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      rom_loaded <= loaded_next;
      rom_valid  <= rom_valid | loaded_next;
      core_reset <= reset_req | (state_reg != ST_IDLE) | ~rom_valid;
    end
  end

endmodule

// File: rtl/arcade_cfg_loader.sv
// Configuration/download front end: variant decode, DIP capture, ROM write
// forwarding and core reset sequencing on top of the hps_io ioctl bus.
module arcade_cfg_loader
  import arcade_cfg_pkg::*;
#(
  parameter int         ADDR_W      = 25,
  parameter int         ROM_AW      = 16,
  parameter int         ROM_SIZE    = 65536,
  parameter int         NUM_MODS    = 18,
  parameter int         NUM_DIP     = 8,
  parameter logic [7:0] DIP_DEFAULT = 8'hFF,
  parameter int         ROM_INDEX   = ROM_IDX,
  parameter int         MOD_INDEX   = MOD_IDX,
  parameter int         DIP_INDEX   = DIP_IDX,
  parameter int         HOLD_CYCLES = 1024
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  arcade_cfg_loader_if.slave     ioctl,
  input  logic                   reset_req,
  output logic [NUM_MODS-1:0]    mod_onehot,
  output logic                   mod_err,
  output logic [NUM_DIP*8-1:0]   dip_flat,
  output logic                   rom_wr,
  output logic [ROM_AW-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic                   rom_loaded,
  output logic                   rom_valid,
  output logic                   core_reset
);

  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W + 1)'(ROM_SIZE);

  logic block_reg;
  logic live;
  logic wr_ok;
  logic sel_rom, sel_mod, sel_dip;
  logic rom_hit;

  // After a reset that lands mid-download, everything is ignored until the
  // download strobe drops, so a half-finished transfer cannot leak through.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      block_reg <= 1'b1;
    end else if (!ioctl.ioctl_download) begin
      block_reg <= 1'b0;
    end
  end

  assign live    = ~(block_reg & ioctl.ioctl_download);
  assign wr_ok   = live & ioctl.ioctl_wr;
  assign sel_rom = (ioctl.ioctl_index == 8'(ROM_INDEX));
  assign sel_mod = (ioctl.ioctl_index == 8'(MOD_INDEX));
  assign sel_dip = (ioctl.ioctl_index == 8'(DIP_INDEX));

  logic [7:0]          mod_raw_reg;
  logic [NUM_MODS-1:0] mod_hit;

  for (genvar gi = 0; gi < NUM_MODS; gi++) begin : g_mod
    assign mod_hit[gi] = (32'(mod_raw_reg) == gi);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      mod_raw_reg <= '0;
      mod_onehot  <= NUM_MODS'(1);
      mod_err     <= 1'b0;
    end else begin
      if (wr_ok && sel_mod && ioctl.ioctl_addr == '0) begin
        mod_raw_reg <= ioctl.ioctl_dout;
      end
      // Out-of-range variants fall back to the base game in bit 0.
      mod_onehot <= mod_hit | NUM_MODS'(~|mod_hit);
      mod_err    <= ~|mod_hit;
    end
  end

  for (genvar gi = 0; gi < NUM_DIP; gi++) begin : g_dip
    logic [7:0] byte_reg;
    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        byte_reg <= DIP_DEFAULT;
      end else if (wr_ok && sel_dip && ioctl.ioctl_addr == ADDR_W'(gi)) begin
        byte_reg <= ioctl.ioctl_dout;
      end
    end
    assign dip_flat[gi*8 +: 8] = byte_reg;
  end

  assign rom_hit = wr_ok & sel_rom & ({1'b0, ioctl.ioctl_addr} < ROM_LIMIT);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rom_wr   <= 1'b0;
      rom_addr <= '0;
      rom_data <= '0;
    end else begin
      rom_wr <= rom_hit;
      if (rom_hit) begin
        rom_addr <= ioctl.ioctl_addr[ROM_AW-1:0];
        rom_data <= ioctl.ioctl_dout;
      end
    end
  end

  dl_reset_seq #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_seq (
    .clk        (clk_sys),
    .reset_n    (reset_n),
    .download   (ioctl.ioctl_download & live),
    .rom_sel    (sel_rom),
    .reset_req  (reset_req),
    .rom_loaded (rom_loaded),
    .rom_valid  (rom_valid),
    .core_reset (core_reset)
  );

endmodule

// File: tb/tb_arcade_cfg_loader.sv
// Directed bench for arcade_cfg_loader: table-driven variant/DIP/ROM vectors
// plus hand sequences for the download/hold/reset timing.
module tb_arcade_cfg_loader;

  localparam int HOLD = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        reset_req;
  logic [17:0] mod_onehot;
  logic        mod_err;
  logic [63:0] dip_flat;
  logic        rom_wr;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_loaded;
  logic        rom_valid;
  logic        core_reset;

  arcade_cfg_loader_if #(.ADDR_W(25)) ioctl ();

  arcade_cfg_loader #(
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ioctl      (ioctl.slave),
    .reset_req  (reset_req),
    .mod_onehot (mod_onehot),
    .mod_err    (mod_err),
    .dip_flat   (dip_flat),
    .rom_wr     (rom_wr),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_loaded (rom_loaded),
    .rom_valid  (rom_valid),
    .core_reset (core_reset)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic        dl;
    logic        wr;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [17:0] onehot;
    logic        err;
    logic [63:0] dip;
    logic        rwr;
    logic [15:0] raddr;
    logic [7:0]  rdata;
  } vec_t;

  localparam logic [63:0] D0 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] D1 = 64'hFFFF_FFFF_FF3C_FFFF;
  localparam logic [63:0] D2 = 64'hA5FF_FFFF_FF3C_FFFF;

  int   n_vec = 0;
  int   n_mis = 0;
  vec_t vecs[21];

  function automatic vec_t mk(logic dl, logic wr, logic [7:0] idx, logic [24:0] addr,
                              logic [7:0] dout, logic [17:0] oh, logic err,
                              logic [63:0] dip, logic rwr, logic [15:0] ra, logic [7:0] rd);
    vec_t v;
    v.dl = dl; v.wr = wr; v.idx = idx; v.addr = addr; v.dout = dout;
    v.onehot = oh; v.err = err; v.dip = dip; v.rwr = rwr; v.raddr = ra; v.rdata = rd;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(logic dl, logic wr, logic [7:0] idx, logic [24:0] addr, logic [7:0] dout);
    ioctl.ioctl_download = dl;
    ioctl.ioctl_wr       = wr;
    ioctl.ioctl_index    = idx;
    ioctl.ioctl_addr     = addr;
    ioctl.ioctl_dout     = dout;
  endtask

  task automatic tick_chk(string tag, logic exp_ld, logic exp_cr);
    tick();
    chk({tag, ".rom_loaded"}, 64'(rom_loaded), 64'(exp_ld));
    chk({tag, ".core_reset"}, 64'(core_reset), 64'(exp_cr));
    $display("%s: rom_loaded=%0b core_reset=%0b", tag, rom_loaded, core_reset);
  endtask

  task automatic rom_byte(logic [24:0] a, logic [7:0] d, logic exp_wr,
                          logic [15:0] exp_a, logic [7:0] exp_d);
    drive(1'b1, 1'b1, 8'd0, a, d);
    tick();
    chk($sformatf("rom_wr@%h", a), 64'(rom_wr), 64'(exp_wr));
    chk($sformatf("rom_addr@%h", a), 64'(rom_addr), 64'(exp_a));
    chk($sformatf("rom_data@%h", a), 64'(rom_data), 64'(exp_d));
    drive(1'b1, 1'b0, 8'd0, a, d);
    tick();
    chk($sformatf("rom_wr_gap@%h", a), 64'(rom_wr), 64'(0));
    $display("rom byte addr=%h data=%h strobe=%0b", a, d, exp_wr);
  endtask

  task automatic hold_window(string tag);
    for (int k = 1; k <= HOLD + 2; k++) begin
      tick_chk($sformatf("%s.k%0d", tag, k), (k == HOLD), (k < HOLD + 1));
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 8'd0,   25'h0,       8'h00, 18'h1,     0, D0, 0, 16'h0,    8'h00);
    vecs[1]  = mk(1, 1, 8'd1,   25'h0,       8'd5,  18'h1,     0, D0, 0, 16'h0,    8'h00);
    vecs[2]  = mk(0, 0, 8'd1,   25'h0,       8'h00, 18'h20,    0, D0, 0, 16'h0,    8'h00);
    vecs[3]  = mk(1, 1, 8'd1,   25'h0,       8'd200,18'h20,    0, D0, 0, 16'h0,    8'h00);
    vecs[4]  = mk(0, 0, 8'd0,   25'h0,       8'h00, 18'h1,     1, D0, 0, 16'h0,    8'h00);
    vecs[5]  = mk(1, 1, 8'd1,   25'h3,       8'd7,  18'h1,     1, D0, 0, 16'h0,    8'h00);
    vecs[6]  = mk(0, 0, 8'd0,   25'h0,       8'h00, 18'h1,     1, D0, 0, 16'h0,    8'h00);
    vecs[7]  = mk(1, 1, 8'd1,   25'h0,       8'd17, 18'h1,     1, D0, 0, 16'h0,    8'h00);
    vecs[8]  = mk(0, 0, 8'd0,   25'h0,       8'h00, 18'h20000, 0, D0, 0, 16'h0,    8'h00);
    vecs[9]  = mk(1, 1, 8'd1,   25'h0,       8'd18, 18'h20000, 0, D0, 0, 16'h0,    8'h00);
    vecs[10] = mk(0, 0, 8'd0,   25'h0,       8'h00, 18'h1,     1, D0, 0, 16'h0,    8'h00);
    vecs[11] = mk(1, 1, 8'd254, 25'h2,       8'h3C, 18'h1,     1, D1, 0, 16'h0,    8'h00);
    vecs[12] = mk(1, 1, 8'd254, 25'h9,       8'h00, 18'h1,     1, D1, 0, 16'h0,    8'h00);
    vecs[13] = mk(1, 1, 8'd254, 25'h7,       8'hA5, 18'h1,     1, D2, 0, 16'h0,    8'h00);
    vecs[14] = mk(1, 1, 8'd254, 25'h8,       8'h00, 18'h1,     1, D2, 0, 16'h0,    8'h00);
    vecs[15] = mk(1, 1, 8'd254, 25'h1000001, 8'h00, 18'h1,     1, D2, 0, 16'h0,    8'h00);
    vecs[16] = mk(0, 1, 8'd0,   25'h1234,    8'h77, 18'h1,     1, D2, 1, 16'h1234, 8'h77);
    vecs[17] = mk(0, 0, 8'd0,   25'h0,       8'h00, 18'h1,     1, D2, 0, 16'h1234, 8'h77);
    vecs[18] = mk(0, 1, 8'd0,   25'hFFFF,    8'h99, 18'h1,     1, D2, 1, 16'hFFFF, 8'h99);
    vecs[19] = mk(0, 1, 8'd0,   25'h10000,   8'h55, 18'h1,     1, D2, 0, 16'hFFFF, 8'h99);
    vecs[20] = mk(0, 0, 8'd0,   25'h0,       8'h00, 18'h1,     1, D2, 0, 16'hFFFF, 8'h99);

    reset_n   = 1'b0;
    reset_req = 1'b0;
    drive(0, 0, 8'd0, 25'h0, 8'h00);
    repeat (3) tick();
    chk("rst.mod_onehot", 64'(mod_onehot), 64'(1));
    chk("rst.mod_err", 64'(mod_err), 64'(0));
    chk("rst.dip_flat", dip_flat, D0);
    chk("rst.rom_loaded", 64'(rom_loaded), 64'(0));
    chk("rst.rom_valid", 64'(rom_valid), 64'(0));
    chk("rst.core_reset", 64'(core_reset), 64'(1));
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].dl, vecs[i].wr, vecs[i].idx, vecs[i].addr, vecs[i].dout);
      tick();
      $display("vec %0d: dl=%0b wr=%0b idx=%0d addr=%h dout=%h", i,
               vecs[i].dl, vecs[i].wr, vecs[i].idx, vecs[i].addr, vecs[i].dout);
      chk($sformatf("v%0d.mod_onehot", i), 64'(mod_onehot), 64'(vecs[i].onehot));
      chk($sformatf("v%0d.mod_err", i), 64'(mod_err), 64'(vecs[i].err));
      chk($sformatf("v%0d.dip_flat", i), dip_flat, vecs[i].dip);
      chk($sformatf("v%0d.rom_wr", i), 64'(rom_wr), 64'(vecs[i].rwr));
      chk($sformatf("v%0d.rom_addr", i), 64'(rom_addr), 64'(vecs[i].raddr));
      chk($sformatf("v%0d.rom_data", i), 64'(rom_data), 64'(vecs[i].rdata));
      chk($sformatf("v%0d.core_reset", i), 64'(core_reset), 64'(1));
      chk($sformatf("v%0d.rom_valid", i), 64'(rom_valid), 64'(0));
    end

    // First ROM download: four bytes plus one out-of-range byte.
    for (int a = 0; a < 4; a++) begin
      rom_byte(25'(a), 8'hA0 + 8'(a), 1'b1, 16'(a), 8'hA0 + 8'(a));
    end
    rom_byte(25'h10000, 8'h55, 1'b0, 16'h3, 8'hA3);
    drive(0, 0, 8'd0, 25'h0, 8'h00);
    tick_chk("dlA.fall", 1'b0, 1'b1);
    hold_window("dlA");
    chk("dlA.rom_valid", 64'(rom_valid), 64'(1));

    reset_req = 1'b1;
    tick_chk("reqon", 1'b0, 1'b1);
    reset_req = 1'b0;
    tick_chk("reqoff", 1'b0, 1'b0);
    chk("req.dip_flat", dip_flat, D2);
    chk("req.mod_onehot", 64'(mod_onehot), 64'(1));

    // Second download restarted part way through the hold.
    drive(1, 0, 8'd0, 25'h0, 8'h00);
    tick_chk("dlB.start", 1'b0, 1'b0);
    tick_chk("dlB.load", 1'b0, 1'b1);
    drive(0, 0, 8'd0, 25'h0, 8'h00);
    tick_chk("dlB.fall1", 1'b0, 1'b1);
    tick_chk("dlB.h1", 1'b0, 1'b1);
    tick_chk("dlB.h2", 1'b0, 1'b1);
    drive(1, 0, 8'd0, 25'h0, 8'h00);
    tick_chk("dlB.restart", 1'b0, 1'b1);
    tick_chk("dlB.reload", 1'b0, 1'b1);
    drive(0, 0, 8'd0, 25'h0, 8'h00);
    tick_chk("dlB.fall2", 1'b0, 1'b1);
    hold_window("dlB");

    // Reset during LOAD; download stays high across the reset release.
    drive(1, 0, 8'd0, 25'h0, 8'h00);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    chk("rstC.core_reset", 64'(core_reset), 64'(1));
    chk("rstC.rom_valid", 64'(rom_valid), 64'(0));
    chk("rstC.rom_addr", 64'(rom_addr), 64'(0));
    chk("rstC.rom_data", 64'(rom_data), 64'(0));
    chk("rstC.dip_flat", dip_flat, D0);
    reset_n = 1'b1;
    drive(1, 1, 8'd0, 25'h5, 8'h11);
    tick();
    chk("rstC.stale_wr", 64'(rom_wr), 64'(0));
    drive(1, 0, 8'd0, 25'h5, 8'h11);
    tick_chk("rstC.dl1", 1'b0, 1'b1);
    drive(0, 0, 8'd0, 25'h0, 8'h00);
    for (int k = 0; k < 8; k++) begin
      tick_chk($sformatf("rstC.idle%0d", k), 1'b0, 1'b1);
    end
    chk("rstC.rom_valid2", 64'(rom_valid), 64'(0));
    rom_byte(25'h6, 8'h22, 1'b1, 16'h6, 8'h22);
    drive(0, 0, 8'd0, 25'h0, 8'h00);
    tick_chk("dlC.fall", 1'b0, 1'b1);
    hold_window("dlC");
    chk("dlC.rom_valid", 64'(rom_valid), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
